// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM-like memory port between instruction fetch and data requesters
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    output logic        stallreq_for_inst,
    output logic        stallreq_for_data,
    output logic        mem_req,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    state_t      state_next;
    logic        owner;
    logic [3:0]  starve_cnt;
    logic        any_req;
    logic        grant_data;
    logic        done;

    // Data wins unless an instruction fetch has already waited out LIMIT data grants.
    assign any_req    = inst_req | data_req;
    assign grant_data = data_req & ~(inst_req & (starve_cnt == LIMIT));

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_next = WAIT_ADDR;
            end
            WAIT_ADDR: begin
                mem_req = 1'b1;
                if (mem_addr_ok) state_next = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (mem_data_ok) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign inst_data_ok      = done & ~owner;
    assign data_data_ok      = done & owner;
    assign inst_rdata        = inst_data_ok ? mem_rdata : 32'd0;
    assign data_rdata        = data_data_ok ? mem_rdata : 32'd0;
    assign stallreq_for_inst = inst_req & ~inst_data_ok;
    assign stallreq_for_data = data_req & ~data_data_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= 4'd0;
            mem_wen    <= 4'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                owner <= grant_data;
                if (grant_data) begin
                    mem_wen   <= data_wen;
                    mem_addr  <= data_addr;
                    mem_wdata <= data_wdata;
                    if (!inst_req)
                        starve_cnt <= 4'd0;
                    else if (starve_cnt < LIMIT)
                        starve_cnt <= starve_cnt + 4'd1;
                end else begin
                    mem_wen    <= 4'd0;
                    mem_addr   <= inst_addr;
                    mem_wdata  <= 32'd0;
                    starve_cnt <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        stallreq_for_inst;
    logic        stallreq_for_data;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_rdata        (inst_rdata),
        .inst_data_ok      (inst_data_ok),
        .data_req          (data_req),
        .data_wen          (data_wen),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_rdata        (data_rdata),
        .data_data_ok      (data_data_ok),
        .stallreq_for_inst (stallreq_for_inst),
        .stallreq_for_data (stallreq_for_data),
        .mem_req           (mem_req),
        .mem_wen           (mem_wen),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_addr_ok       (mem_addr_ok),
        .mem_data_ok       (mem_data_ok),
        .mem_rdata         (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller has set the requests in an IDLE cycle; memory answers with no wait states.
    task automatic txn(input logic is_data, input logic [31:0] exp_addr,
                       input logic [3:0] exp_wen, input logic [31:0] rd);
        #1;
        check("idle_mem_req", 32'(mem_req), 32'd0);
        step();
        check("wa_mem_req", 32'(mem_req), 32'd1);
        check("wa_mem_addr", mem_addr, exp_addr);
        check("wa_mem_wen", 32'(mem_wen), 32'(exp_wen));
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        #1;
        check("wd_mem_req", 32'(mem_req), 32'd0);
        check("wd_inst_ok", 32'(inst_data_ok), 32'(!is_data));
        check("wd_data_ok", 32'(data_data_ok), 32'(is_data));
        if (is_data) check("wd_data_rdata", data_rdata, rd);
        else         check("wd_inst_rdata", inst_rdata, rd);
        step();
        mem_data_ok = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wen = 4'd0; data_addr = 32'd0; data_wdata = 32'd0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_oks", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        check("rst_stalls", {30'd0, stallreq_for_inst, stallreq_for_data}, 32'd0);
        step(); step();
        rst = 1'b1;
        step();

        // Single instruction read, zero wait states
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        #1;
        check("t1_c0_stall", 32'(stallreq_for_inst), 32'd1);
        check("t1_c0_mem_req", 32'(mem_req), 32'd0);
        step();
        mem_addr_ok = 1'b1;
        #1;
        check("t1_c1_mem_req", 32'(mem_req), 32'd1);
        check("t1_c1_mem_addr", mem_addr, 32'hBFC0_0000);
        check("t1_c1_mem_wen", 32'(mem_wen), 32'd0);
        check("t1_c1_stall", 32'(stallreq_for_inst), 32'd1);
        check("t1_c1_ok", 32'(inst_data_ok), 32'd0);
        step();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C1D_8000;
        #1;
        check("t1_c2_ok", 32'(inst_data_ok), 32'd1);
        check("t1_c2_rdata", inst_rdata, 32'h3C1D_8000);
        check("t1_c2_stall", 32'(stallreq_for_inst), 32'd0);
        check("t1_c2_mem_req", 32'(mem_req), 32'd0);
        step();
        inst_req = 1'b0; mem_data_ok = 1'b0;
        #1;
        check("t1_c3_ok", 32'(inst_data_ok), 32'd0);
        check("t1_c3_mem_req", 32'(mem_req), 32'd0);

        // Data write with 3 addr wait cycles and 2 data wait cycles
        data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h8000_1004; data_wdata = 32'hDEAD_BEEF;
        #1;
        check("t2_grant_stall", 32'(stallreq_for_data), 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            mem_addr_ok = (i == 3);
            #1;
            check("t2_wa_mem_req", 32'(mem_req), 32'd1);
            check("t2_wa_mem_addr", mem_addr, 32'h8000_1004);
            check("t2_wa_mem_wen", 32'(mem_wen), 32'h3);
            check("t2_wa_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("t2_wa_ok", 32'(data_data_ok), 32'd0);
            step();
        end
        mem_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_data_ok = (i == 2);
            #1;
            check("t2_wd_mem_req", 32'(mem_req), 32'd0);
            check("t2_wd_ok", 32'(data_data_ok), 32'(i == 2));
            check("t2_wd_stall", 32'(stallreq_for_data), 32'(i != 2));
            step();
        end
        mem_data_ok = 1'b0; data_req = 1'b0; data_wen = 4'd0;
        #1;
        check("t2_after_ok", 32'(data_data_ok), 32'd0);

        // Simultaneous requests: data first, inst right after
        inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
        data_req = 1'b1; data_addr = 32'h8000_2000;
        txn(1'b1, 32'h8000_2000, 4'd0, 32'h1111_2222);
        data_req = 1'b0;
        txn(1'b0, 32'hBFC0_0010, 4'd0, 32'h3333_4444);
        inst_req = 1'b0;

        // Starvation bound: D,D,D,D,I repeated twice
        inst_req = 1'b1; inst_addr = 32'hBFC0_0020; data_req = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                data_addr = 32'h8000_3000 + 32'(r * 256 + k * 4);
                txn(1'b1, data_addr, 4'd0, 32'hA000_0000 + 32'(r * 16 + k));
            end
            data_addr = 32'h8000_3080 + 32'(r * 256);
            txn(1'b0, 32'hBFC0_0020, 4'd0, 32'hC000_0000 + 32'(r));
        end
        txn(1'b1, 32'h8000_3180, 4'd0, 32'h5555_6666);
        inst_req = 1'b0; data_req = 1'b0;

        // Spurious mem_data_ok in IDLE and WAIT_ADDR
        mem_data_ok = 1'b1;
        #1;
        check("sp_idle_oks", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        step();
        mem_data_ok = 1'b0;
        #1;
        check("sp_idle_mem_req", 32'(mem_req), 32'd0);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0040;
        step();
        mem_data_ok = 1'b1;
        #1;
        check("sp_wa_ok", 32'(inst_data_ok), 32'd0);
        step();
        mem_data_ok = 1'b0;
        #1;
        check("sp_wa_hold", 32'(mem_req), 32'd1);
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;

        // Reset in WAIT_DATA, with a response arriving at the same time
        mem_data_ok = 1'b1; mem_rdata = 32'h7777_8888;
        rst = 1'b0;
        #1;
        check("rst_wd_ok", 32'(inst_data_ok), 32'd0);
        check("rst_wd_rdata", inst_rdata, 32'd0);
        check("rst_wd_mem_req", 32'(mem_req), 32'd0);
        check("rst_wd_mem_addr", mem_addr, 32'd0);
        step();
        mem_data_ok = 1'b0;
        rst = 1'b1;
        txn(1'b0, 32'hBFC0_0040, 4'd0, 32'h9999_0000);
        inst_req = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one external SRAM-like memory port between the core's instruction-fetch requester (IF) and data requester (EX/MEM).
- Runs the memory handshake through a 3-state FSM with one outstanding transaction.
- Data requests have priority. A starvation counter bounds instruction delay.
- Raises per-requester stall requests into CTRL so the pipeline freezes while an access is pending.

Parameters:
- STARVE_LIMIT, 4, number of consecutive data grants allowed while an inst request waits; legal range 1..15.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- inst_req  in  1  instruction access request; held until inst_data_ok.
- inst_addr  in  32  fetch address.
- inst_rdata  out  32  fetch data; valid only while inst_data_ok=1.
- inst_data_ok  out  1  one-cycle completion pulse for inst.
- data_req  in  1  data access request; held until data_data_ok.
- data_wen  in  4  byte write enables; 0 means read.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_rdata  out  32  load data; valid only while data_data_ok=1.
- data_data_ok  out  1  one-cycle completion pulse for data.
- stallreq_for_inst  out  1  to CTRL; equals inst_req & ~inst_data_ok.
- stallreq_for_data  out  1  to CTRL; equals data_req & ~data_data_ok.
- mem_req  out  1  memory request valid.
- mem_wen  out  4  latched byte enables; 0 for inst accesses.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched store data.
- mem_addr_ok  in  1  memory accepted the request this cycle.
- mem_data_ok  in  1  read data or write acknowledge returned this cycle.
- mem_rdata  in  32  memory read data.

Behaviour:
- States: IDLE, WAIT_ADDR, WAIT_DATA. Owner register: 0 = inst, 1 = data.
- Reset (rst=0, asynchronous) clears everything:
  - State goes to IDLE; owner, mem_wen, mem_addr, mem_wdata and the starvation counter go to 0.
  - Every output is 0, including mem_req, both data_ok pulses, and both stall requests when their req is low.
- IDLE grant rule:
  - If any req is high, grant data when data_req=1 and NOT (inst_req=1 and starve_cnt==STARVE_LIMIT); otherwise grant inst.
  - On the grant cycle, latch the winner's addr, wen and wdata into the mem_* registers (inst: wen=0, wdata=0), set owner, and go to WAIT_ADDR.
  - If no req is high, stay in IDLE.
- Starvation counter (4-bit):
  - Data grant with inst_req=1: increment, saturating at STARVE_LIMIT.
  - Data grant with inst_req=0: clear.
  - Any inst grant: clear.
- WAIT_ADDR:
  - mem_req=1. The mem_* outputs are stable, taken from the latches.
  - On mem_addr_ok=1, go to WAIT_DATA in the next cycle; otherwise hold state.
- WAIT_DATA:
  - mem_req=0.
  - On mem_data_ok=1, the owner's data_ok is driven high combinationally in that same cycle, its rdata equals mem_rdata, and the next state is IDLE.
  - Writes also complete on mem_data_ok; data_rdata is don't-care for writes.
- mem_data_ok in IDLE or WAIT_ADDR is ignored: no data_ok pulse and no state change.
- The non-owner's data_ok is always 0. The rdata of a requester whose data_ok is low is don't-care.
- Latency: req first seen high at cycle N with mem_addr_ok=1 at N+1 and mem_data_ok=1 at N+2 gives data_ok at N+2, which is the minimum. Each extra wait cycle on the memory side adds one cycle.
- Back-to-back: the requester may present a new req in the cycle after its data_ok, and that cycle is IDLE, so the grant happens then. Throughput is at most one access per 3 cycles.
- Requesters keep addr, wen and wdata stable while req is high. The arbiter samples them only on the grant cycle.
- A requester dropping req after grant is a protocol violation. The transaction still completes and its data_ok pulse is still produced.
- If reset asserts mid-transaction, the FSM aborts to IDLE. The memory is reset with the same rst, so no stale response arrives.

Test Plan:
- Single inst read, mem responds immediately: inst_req=1, addr 0xBFC00000 at cycle 0; addr_ok at 1; data_ok at 2 with rdata 0x3C1D8000 -> mem_req=1 only in cycle 1, mem_wen=0, inst_data_ok=1 with inst_rdata=0x3C1D8000 at cycle 2, stallreq_for_inst=1 in cycles 0-1.
- Data write under memory wait states: data_wen=4'b0011, addr 0x80001004, wdata 0xDEADBEEF; addr_ok delayed 3 cycles, data_ok delayed 2 more -> mem_* outputs stable throughout WAIT_ADDR, data_data_ok pulses exactly once, stallreq_for_data stays high until that pulse.
- Simultaneous requests: inst_req and data_req both rise at cycle 0 -> data granted first (mem_addr=data_addr); inst granted in the IDLE cycle after data_data_ok.
- Starvation with STARVE_LIMIT=4: data_req held high continuously with a new address after each completion, and inst_req high throughout -> grants go D,D,D,D,I,D...; starve_cnt returns to 0 after the inst grant.
- Spurious and reset cases:
  - mem_data_ok=1 in IDLE -> no data_ok pulse, no state change.
  - rst=0 during WAIT_DATA -> all outputs 0 immediately, no data_ok pulse.
  - After rst rises again with inst_req still high -> the next access begins from IDLE.
